// File: rtl/aibcr3aux_osc_scan_pkg.sv
// -----------------------------------------------------------------------------
// aibcr3aux_osc_scan_pkg
// Shared definitions for the aux oscillator scan-chain sequencer.
//   - Command op encodings presented on cmd_op.
//   - Sequencer FSM state encoding.
// -----------------------------------------------------------------------------
package aibcr3aux_osc_scan_pkg;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_CAPT  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEPT = 3'd1,
    CAPT   = 3'd2,
    SHIFT  = 3'd3,
    VERIFY = 3'd4,
    DONE   = 3'd5
  } state_e;

endpackage

// File: rtl/aibcr3aux_osc_scan_sreg.sv
// -----------------------------------------------------------------------------
// aibcr3aux_osc_scan_sreg
// Data path for the scan sequencer: a write register loaded in parallel at
// command accept and read out one bit at a time, plus a capture register that
// collects so samples one bit at a time. Both use the same bit index.
// Ports:
//   i_cp       clock (chain clock)
//   i_rst      asynchronous reset, active-high
//   i_load     parallel-load strobe for the write register
//   i_wdata    write data to load
//   i_idx      shared bit index (current shift cycle)
//   i_cap_en   capture strobe: store i_cap_bit at bit i_idx
//   i_cap_bit  serial capture input (chain so)
//   o_wbit     write register bit selected by i_idx
//   o_rdata    capture register contents
// -----------------------------------------------------------------------------
module aibcr3aux_osc_scan_sreg
  import aibcr3aux_osc_scan_pkg::*;
#(
  parameter int W  = 16,
  parameter int IW = 5
) (
  input  logic          i_cp,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic [W-1:0]  i_wdata,
  input  logic [IW-1:0] i_idx,
  input  logic          i_cap_en,
  input  logic          i_cap_bit,
  output logic          o_wbit,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_wreg;
  logic [W-1:0] r_rdata;
  logic [W-1:0] w_wsh;

  // Write register: loaded once per command, then held for shift and verify.
  always_ff @(posedge i_cp or posedge i_rst) begin
    if (i_rst) begin
      r_wreg <= '0;
    end else if (i_load) begin
      r_wreg <= i_wdata;
    end else begin
      r_wreg <= r_wreg;
    end
  end

  // Serial-out selection; a shift avoids indexing with an over-wide counter.
  always_comb begin
    w_wsh  = r_wreg >> i_idx;
    o_wbit = w_wsh[0];
  end

  // Capture register: bit i receives the pre-shift so of shift cycle i.
  always_ff @(posedge i_cp or posedge i_rst) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else begin
      for (int b = 0; b < W; b++) begin
        if (i_cap_en && (i_idx == IW'(b))) begin
          r_rdata[b] <= i_cap_bit;
        end else begin
          r_rdata[b] <= r_rdata[b];
        end
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/aibcr3aux_osc_scan_ctrl.sv
// -----------------------------------------------------------------------------
// aibcr3aux_osc_scan_ctrl
// Sequencer for the aux oscillator scan-flop chain. Runs WRITE (serial load,
// optional recirculating verify), READ (recirculating readback) and CAPTURE
// (one functional capture cycle, then readback).
// Ports:
//   i_cp         chain clock
//   i_rst        asynchronous reset, active-high
//   i_cmd_req    command request, sampled only while idle
//   i_cmd_op     command op (00 WRITE, 01 READ, 10 CAPTURE, 11 reserved)
//   i_cmd_wdata  write data, captured on accept
//   o_busy       high from the accept edge through the done cycle
//   o_done       one-cycle completion pulse
//   o_err        sticky error (reserved op or verify mismatch), cleared on accept
//   o_rdata      chain contents from the most recent shift-out
//   o_se_n       chain scan enable, active-low
//   o_si         chain serial input
//   i_so         chain serial output (last flop)
// -----------------------------------------------------------------------------
module aibcr3aux_osc_scan_ctrl
  import aibcr3aux_osc_scan_pkg::*;
#(
  parameter int CHAIN_LEN = 16,
  parameter int VERIFY_EN = 1
) (
  input  logic                 i_cp,
  input  logic                 i_rst,
  input  logic                 i_cmd_req,
  input  logic [1:0]           i_cmd_op,
  input  logic [CHAIN_LEN-1:0] i_cmd_wdata,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic [CHAIN_LEN-1:0] o_rdata,
  output logic                 o_se_n,
  output logic                 o_si,
  input  logic                 i_so
);

  localparam int              CW       = $clog2(CHAIN_LEN + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(CHAIN_LEN - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [1:0]    r_op;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic          r_se_n;
  logic          w_accept;
  logic          w_err_set;
  logic          w_shifting;
  logic          w_wr_shift;
  logic          w_last;
  logic          w_wbit;

  assign w_shifting = (r_state == SHIFT) || (r_state == VERIFY);
  assign w_wr_shift = (r_state == SHIFT) && (r_op == OP_WRITE);
  assign w_last     = (r_cnt == CNT_LAST);

  // Next-state, bit counter and error-set decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_cmd_req) begin
          w_state_nxt = ACCEPT;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ACCEPT: begin
        case (r_op)
          OP_WRITE, OP_READ: w_state_nxt = SHIFT;
          OP_CAPT:           w_state_nxt = CAPT;
          default: begin
            w_state_nxt = DONE;
            w_err_set   = 1'b1;
          end
        endcase
      end
      CAPT: begin
        w_state_nxt = SHIFT;
      end
      SHIFT: begin
        if (w_last) begin
          w_cnt_nxt = '0;
          if ((r_op == OP_WRITE) && (VERIFY_EN != 0)) begin
            w_state_nxt = VERIFY;
          end else begin
            w_state_nxt = DONE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      VERIFY: begin
        // Recirculated chain bit must match the bit written in the same slot.
        if (i_so != w_wbit) begin
          w_err_set = 1'b1;
        end else begin
          w_err_set = 1'b0;
        end
        if (w_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = DONE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, bit counter and latched command op.
  always_ff @(posedge i_cp or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_op    <= OP_WRITE;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_op <= i_cmd_op;
      end else begin
        r_op <= r_op;
      end
    end
  end

  // Status and scan-enable outputs, registered from the next-state decode.
  always_ff @(posedge i_cp or posedge i_rst) begin
    if (i_rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_se_n <= 1'b1;
      r_err  <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != IDLE);
      r_done <= (w_state_nxt == DONE);
      r_se_n <= !((w_state_nxt == SHIFT) || (w_state_nxt == VERIFY));
      if (w_accept) begin
        r_err <= 1'b0;
      end else if (w_err_set) begin
        r_err <= 1'b1;
      end else begin
        r_err <= r_err;
      end
    end
  end

  // si must follow so within the same cycle to recirculate, so it is a mux
  // rather than a register.
  always_comb begin
    if (w_wr_shift) begin
      o_si = w_wbit;
    end else if (w_shifting) begin
      o_si = i_so;
    end else begin
      o_si = 1'b0;
    end
  end

  aibcr3aux_osc_scan_sreg #(
    .W  (CHAIN_LEN),
    .IW (CW)
  ) u_sreg (
    .i_cp      (i_cp),
    .i_rst     (i_rst),
    .i_load    (w_accept),
    .i_wdata   (i_cmd_wdata),
    .i_idx     (r_cnt),
    .i_cap_en  (w_shifting),
    .i_cap_bit (i_so),
    .o_wbit    (w_wbit),
    .o_rdata   (o_rdata)
  );

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_err  = r_err;
  assign o_se_n = r_se_n;

endmodule

// File: tb/tb_aibcr3aux_osc_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aibcr3aux_osc_scan_ctrl
// Bench for the oscillator scan sequencer with an 8-flop scan chain model.
// The chain value V is defined so that V[i] is the bit that appears on so in
// shift cycle i (V[i] = q[L-1-i]); the reference model works on V only.
// -----------------------------------------------------------------------------
module tb_aibcr3aux_osc_scan_ctrl;

  localparam int         L          = 8;
  localparam int         UPSET_FLOP = L - 4;   // flop that holds V[3]
  localparam logic [1:0] C_WRITE    = 2'b00;
  localparam logic [1:0] C_READ     = 2'b01;
  localparam logic [1:0] C_CAPT     = 2'b10;
  localparam logic [1:0] C_RSVD     = 2'b11;

  logic         cp = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_req = 1'b0;
  logic [1:0]   cmd_op = 2'b00;
  logic [L-1:0] cmd_wdata = '0;
  logic         busy, done, err, se_n, si, so;
  logic [L-1:0] rdata;

  // chain model controls
  logic         pre_en = 1'b1;
  logic [L-1:0] pre_val = '0;
  logic         func_en = 1'b0;
  logic [L-1:0] func_val = '0;
  logic         upset_arm = 1'b0;
  int           shift_run = 0;
  logic [L-1:0] q, q_nxt, sh;

  int total = 0;
  int bad = 0;

  // observations and expectations
  int           o_lat, o_low, x_lat, x_low;
  logic         o_c1, o_bok, o_err, x_err;
  logic [L-1:0] o_rd, o_mid, x_rd, x_mid;

  // reference model state
  logic [L-1:0] m_chain = '0;
  logic [L-1:0] m_rdata = '0;
  bit           m_known = 1'b1;

  always #5 cp = ~cp;

  aibcr3aux_osc_scan_ctrl #(.CHAIN_LEN(L), .VERIFY_EN(1)) dut (
    .i_cp        (cp),
    .i_rst       (rst),
    .i_cmd_req   (cmd_req),
    .i_cmd_op    (cmd_op),
    .i_cmd_wdata (cmd_wdata),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err),
    .o_rdata     (rdata),
    .o_se_n      (se_n),
    .o_si        (si),
    .i_so        (so)
  );

  // Scan chain: q[0] is next to si, q[L-1] drives so.
  assign so = q[L-1];
  always_comb begin
    sh = {q[L-2:0], si};
    if (upset_arm && (shift_run == L - 1)) sh[UPSET_FLOP] = 1'b0;
    if (!se_n)        q_nxt = sh;
    else if (pre_en)  q_nxt = pre_val;
    else if (func_en) q_nxt = func_val;
    else              q_nxt = q;
  end
  always @(posedge cp) begin
    q <= q_nxt;
    shift_run <= (se_n !== 1'b0) ? 0 : shift_run + 1;
  end

  function automatic logic [L-1:0] rev(input logic [L-1:0] v);
    logic [L-1:0] r;
    for (int i = 0; i < L; i++) r[i] = v[L-1-i];
    return r;
  endfunction

  // Reference model: outcome of one command from the chain value alone.
  task automatic predict(input logic [1:0] op, input logic [L-1:0] wd,
                         input logic [L-1:0] dval, input bit upset);
    logic [L-1:0] landed;
    x_mid = m_chain;
    case (op)
      C_WRITE: begin
        landed = wd;
        if (upset) landed[3] = 1'b0;
        x_lat = 2*L + 1; x_low = 2*L; x_rd = landed; x_err = (landed != wd);
        m_chain = landed;
      end
      C_READ: begin
        x_lat = L + 1; x_low = L; x_rd = m_chain; x_err = 1'b0;
      end
      C_CAPT: begin
        x_lat = L + 2; x_low = L; x_rd = dval; x_err = 1'b0;
        m_chain = dval;
      end
      default: begin
        x_lat = 1; x_low = 0; x_rd = m_rdata; x_err = 1'b1;
      end
    endcase
    m_rdata = x_rd;
  endtask

  // Issue one command from an idle negedge and record what the DUT does.
  task automatic run_cmd(input logic [1:0] op, input logic [L-1:0] wd, input bit hold);
    cmd_req = 1'b1; cmd_op = op; cmd_wdata = wd;
    @(negedge cp);
    o_bok = (busy === 1'b1) && (done === 1'b0);
    if (!hold) cmd_req = 1'b0;
    cmd_wdata = L'($urandom);
    o_lat = -1; o_low = 0; o_c1 = 1'b1; o_mid = '0;
    for (int c = 1; c <= 4*L + 8; c++) begin
      @(negedge cp);
      if (se_n === 1'b0) o_low++;
      if (c == 1) o_c1 = se_n;
      if (c == L + 1) o_mid = rdata;
      if (busy !== 1'b1) o_bok = 1'b0;
      if (done === 1'b1) begin o_lat = c; break; end
    end
    o_err = err; o_rd = rdata;
    @(negedge cp);
    if ((busy !== 1'b0) || (done !== 1'b0)) o_bok = 1'b0;
  endtask

  task automatic test_reset;
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0)  begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (err !== 1'b0)   begin bad++; $display("FAIL reset_err: got %b want 0", err); end
    total++; if (se_n !== 1'b1)  begin bad++; $display("FAIL reset_se_n: got %b want 1", se_n); end
    total++; if (si !== 1'b0)    begin bad++; $display("FAIL reset_si: got %b want 0", si); end
    total++; if (rdata !== '0)   begin bad++; $display("FAIL reset_rdata: got %h want 00", rdata); end
  endtask

  task automatic test_write_verify;
    predict(C_WRITE, 8'hA5, '0, 1'b0);
    run_cmd(C_WRITE, 8'hA5, 1'b0);
    total++; if (o_lat != x_lat) begin bad++; $display("FAIL wr_latency: got %0d want %0d", o_lat, x_lat); end
    total++; if (o_low != x_low) begin bad++; $display("FAIL wr_se_low: got %0d want %0d", o_low, x_low); end
    total++; if (o_c1 !== 1'b0)  begin bad++; $display("FAIL wr_se_c1: got %b want 0", o_c1); end
    total++; if (o_mid !== x_mid) begin bad++; $display("FAIL wr_prev: got %h want %h", o_mid, x_mid); end
    total++; if (o_rd !== x_rd)  begin bad++; $display("FAIL wr_rdata: got %h want %h", o_rd, x_rd); end
    total++; if (o_err !== x_err) begin bad++; $display("FAIL wr_err: got %b want %b", o_err, x_err); end
    total++; if (o_bok !== 1'b1) begin bad++; $display("FAIL wr_busy: got %b want 1", o_bok); end
  endtask

  task automatic test_read;
    predict(C_WRITE, 8'h3C, '0, 1'b0);
    run_cmd(C_WRITE, 8'h3C, 1'b0);
    total++; if (o_rd !== x_rd) begin bad++; $display("FAIL rd_prep: got %h want %h", o_rd, x_rd); end
    for (int n = 0; n < 2; n++) begin
      predict(C_READ, '0, '0, 1'b0);
      run_cmd(C_READ, L'($urandom), 1'b0);
      total++; if (o_lat != x_lat) begin bad++; $display("FAIL rd_latency%0d: got %0d want %0d", n, o_lat, x_lat); end
      total++; if (o_low != x_low) begin bad++; $display("FAIL rd_se_low%0d: got %0d want %0d", n, o_low, x_low); end
      total++; if (o_rd !== x_rd)  begin bad++; $display("FAIL rd_rdata%0d: got %h want %h", n, o_rd, x_rd); end
      total++; if (rev(q) !== m_chain) begin bad++; $display("FAIL rd_chain%0d: got %h want %h", n, rev(q), m_chain); end
      total++; if (o_bok !== 1'b1) begin bad++; $display("FAIL rd_busy%0d: got %b want 1", n, o_bok); end
    end
  endtask

  task automatic test_capture;
    func_val = rev(8'h5A); func_en = 1'b1;
    predict(C_CAPT, '0, 8'h5A, 1'b0);
    run_cmd(C_CAPT, '0, 1'b0);
    func_en = 1'b0;
    total++; if (o_c1 !== 1'b1)  begin bad++; $display("FAIL cap_se_c1: got %b want 1", o_c1); end
    total++; if (o_lat != x_lat) begin bad++; $display("FAIL cap_latency: got %0d want %0d", o_lat, x_lat); end
    total++; if (o_low != x_low) begin bad++; $display("FAIL cap_se_low: got %0d want %0d", o_low, x_low); end
    total++; if (o_rd !== x_rd)  begin bad++; $display("FAIL cap_rdata: got %h want %h", o_rd, x_rd); end
  endtask

  // Bit 3 of the chain drops to 0 as the write pass completes.
  task automatic test_verify_fault;
    upset_arm = 1'b1;
    predict(C_WRITE, 8'hFF, '0, 1'b1);
    run_cmd(C_WRITE, 8'hFF, 1'b0);
    upset_arm = 1'b0;
    total++; if (o_err !== 1'b1) begin bad++; $display("FAIL vf_err: got %b want 1", o_err); end
    total++; if (o_rd !== x_rd)  begin bad++; $display("FAIL vf_rdata: got %h want %h", o_rd, x_rd); end
    total++; if (o_lat != x_lat) begin bad++; $display("FAIL vf_latency: got %0d want %0d", o_lat, x_lat); end
    predict(C_READ, '0, '0, 1'b0);
    run_cmd(C_READ, '0, 1'b0);
    total++; if (o_err !== 1'b0) begin bad++; $display("FAIL vf_err_clr: got %b want 0", o_err); end
    total++; if (o_rd !== x_rd)  begin bad++; $display("FAIL vf_readback: got %h want %h", o_rd, x_rd); end
  endtask

  task automatic test_reserved;
    predict(C_RSVD, '0, '0, 1'b0);
    run_cmd(C_RSVD, L'($urandom), 1'b0);
    total++; if (o_lat != x_lat) begin bad++; $display("FAIL rsvd_latency: got %0d want %0d", o_lat, x_lat); end
    total++; if (o_low != x_low) begin bad++; $display("FAIL rsvd_se_low: got %0d want %0d", o_low, x_low); end
    total++; if (o_err !== x_err) begin bad++; $display("FAIL rsvd_err: got %b want %b", o_err, x_err); end
    total++; if (o_rd !== x_rd)  begin bad++; $display("FAIL rsvd_rdata: got %h want %h", o_rd, x_rd); end
  endtask

  // cmd_req held high across a READ: the done cycle must not accept, the
  // following idle cycle shows busy=0, and the next edge accepts.
  task automatic test_back_to_back;
    predict(C_READ, '0, '0, 1'b0);
    run_cmd(C_READ, '0, 1'b1);
    total++; if (o_lat != x_lat) begin bad++; $display("FAIL b2b_latency: got %0d want %0d", o_lat, x_lat); end
    total++; if (o_bok !== 1'b1) begin bad++; $display("FAIL b2b_busy: got %b want 1", o_bok); end
    predict(C_READ, '0, '0, 1'b0);
    run_cmd(C_READ, '0, 1'b0);
    total++; if (o_bok !== 1'b1) begin bad++; $display("FAIL b2b_accept: got %b want 1", o_bok); end
    total++; if (o_rd !== x_rd)  begin bad++; $display("FAIL b2b_rdata: got %h want %h", o_rd, x_rd); end
  endtask

  task automatic test_reset_mid_write;
    bit saw;
    cmd_req = 1'b1; cmd_op = C_WRITE; cmd_wdata = 8'h5E;
    @(negedge cp);
    cmd_req = 1'b0;
    repeat (4) @(negedge cp);
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (se_n !== 1'b1)  begin bad++; $display("FAIL rst_se_n: got %b want 1", se_n); end
    total++; if (si !== 1'b0)    begin bad++; $display("FAIL rst_si: got %b want 0", si); end
    total++; if (rdata !== '0)   begin bad++; $display("FAIL rst_rdata: got %h want 00", rdata); end
    total++; if (done !== 1'b0)  begin bad++; $display("FAIL rst_done: got %b want 0", done); end
    @(negedge cp);
    rst = 1'b0;
    saw = 1'b0;
    repeat (3*L) begin
      @(negedge cp);
      if ((done !== 1'b0) || (busy !== 1'b0)) saw = 1'b1;
    end
    total++; if (saw) begin bad++; $display("FAIL rst_no_done: got activity want none"); end
    m_known = 1'b0; m_rdata = '0;
    predict(C_WRITE, 8'h81, '0, 1'b0);
    run_cmd(C_WRITE, 8'h81, 1'b0);
    m_known = 1'b1;
    total++; if (o_lat != x_lat) begin bad++; $display("FAIL rst_wr_latency: got %0d want %0d", o_lat, x_lat); end
    total++; if (o_err !== 1'b0) begin bad++; $display("FAIL rst_wr_err: got %b want 0", o_err); end
    total++; if (o_rd !== x_rd)  begin bad++; $display("FAIL rst_wr_rdata: got %h want %h", o_rd, x_rd); end
  endtask

  task automatic test_random;
    logic [1:0]   op;
    logic [L-1:0] wd, dv;
    bit           known;
    for (int n = 0; n < 24; n++) begin
      op = 2'($urandom_range(0, 3));
      wd = L'($urandom);
      dv = L'($urandom);
      known = m_known;
      repeat ($urandom_range(0, 3)) @(negedge cp);
      if (op == C_CAPT) begin func_val = rev(dv); func_en = 1'b1; end
      predict(op, wd, dv, 1'b0);
      run_cmd(op, wd, 1'b0);
      func_en = 1'b0;
      total++; if (o_lat != x_lat) begin bad++; $display("FAIL rnd%0d_latency op=%0d: got %0d want %0d", n, op, o_lat, x_lat); end
      total++; if (o_low != x_low) begin bad++; $display("FAIL rnd%0d_se_low op=%0d: got %0d want %0d", n, op, o_low, x_low); end
      total++; if (o_err !== x_err) begin bad++; $display("FAIL rnd%0d_err op=%0d: got %b want %b", n, op, o_err, x_err); end
      total++; if (o_rd !== x_rd)  begin bad++; $display("FAIL rnd%0d_rdata op=%0d: got %h want %h", n, op, o_rd, x_rd); end
      total++; if (o_bok !== 1'b1) begin bad++; $display("FAIL rnd%0d_busy op=%0d: got %b want 1", n, op, o_bok); end
      if ((op == C_WRITE) && known) begin
        total++; if (o_mid !== x_mid) begin bad++; $display("FAIL rnd%0d_prev: got %h want %h", n, o_mid, x_mid); end
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge cp);
    test_reset();
    rst = 1'b0;
    pre_en = 1'b0;
    @(negedge cp);
    test_write_verify();
    test_read();
    test_capture();
    test_verify_fault();
    test_reserved();
    test_back_to_back();
    test_reset_mid_write();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
